// File: rtl/sort_merge_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sort_merge_scheduler
// Description : RAM_N-way merge of independently sorted banks onto an
//               Avalon-ST source; define SORT_MERGE_DESCENDING_EN for max-first.
// Revision    : 1.0 - initial release
// ============================================================================
module sort_merge_scheduler #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 8,
  parameter int RAM_N  = 4
) (
  input  logic                        clk_i,
  input  logic                        srst_i,
  input  logic                        start_i,
  input  logic [RAM_N*(AWIDTH+1)-1:0] bank_len_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [RAM_N-1:0]            rd_en_o,
  output logic [RAM_N*AWIDTH-1:0]     rd_addr_o,
  input  logic [RAM_N*DWIDTH-1:0]     rd_data_i,
  output logic [DWIDTH-1:0]           src_data_o,
  output logic                        src_valid_o,
  output logic                        src_startofpacket_o,
  output logic                        src_endofpacket_o,
  input  logic                        src_ready_i
);

  localparam int LW = AWIDTH + 1;
  localparam int SW = $clog2(RAM_N);
  localparam int TW = LW + SW;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PRIME  = 2'd1,
    S_WAIT   = 2'd2,
    S_OUTPUT = 2'd3
  } state_t;

  state_t             r_state;
  logic [LW-1:0]      r_rem  [RAM_N];
  logic [AWIDTH-1:0]  r_addr [RAM_N];
  logic [DWIDTH-1:0]  r_head [RAM_N];
  logic [RAM_N-1:0]   r_hv;
  logic [RAM_N-1:0]   r_pend;
  logic [TW-1:0]      r_total;
  logic               r_first;
  logic               r_done;

  logic [TW-1:0]      w_len_sum;
  logic [SW-1:0]      w_sel;
  logic [DWIDTH-1:0]  w_best;
  logic               w_found;
  logic               w_hs;
  logic [LW-1:0]      w_sel_rem;
  logic               w_refill;

  always_comb begin
    w_len_sum = '0;
    for (int i = 0; i < RAM_N; i++) begin
      w_len_sum = w_len_sum + TW'(bank_len_i[i*LW +: LW]);
    end
  end

  // Strict comparison keeps the lowest-index bank on ties.
  always_comb begin
    w_sel   = '0;
    w_best  = '0;
    w_found = 1'b0;
    for (int i = 0; i < RAM_N; i++) begin
      if (r_hv[i]) begin
`ifdef SORT_MERGE_DESCENDING_EN
        if (!w_found || (r_head[i] > w_best)) begin
`else
        if (!w_found || (r_head[i] < w_best)) begin
`endif
          w_found = 1'b1;
          w_best  = r_head[i];
          w_sel   = SW'(i);
        end
      end
    end
  end

  assign w_hs      = (r_state == S_OUTPUT) && src_ready_i;
  assign w_sel_rem = r_rem[w_sel];
  assign w_refill  = w_hs && (w_sel_rem != LW'(1));

  always_comb begin
    rd_en_o = '0;
    for (int i = 0; i < RAM_N; i++) begin
      rd_en_o[i] = ((r_state == S_PRIME) && (r_rem[i] != '0)) ||
                   (w_refill && (w_sel == SW'(i)));
    end
  end

  // r_addr tracks the address of the next word to fetch for each bank.
  for (genvar g = 0; g < RAM_N; g++) begin : g_rd_addr
    assign rd_addr_o[g*AWIDTH +: AWIDTH] = r_addr[g];
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_state <= S_IDLE;
      r_hv    <= '0;
      r_pend  <= '0;
      r_total <= '0;
      r_first <= 1'b0;
      r_done  <= 1'b0;
      for (int i = 0; i < RAM_N; i++) begin
        r_rem[i]  <= '0;
        r_addr[i] <= '0;
        r_head[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      r_pend <= rd_en_o;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            for (int i = 0; i < RAM_N; i++) begin
              r_rem[i]  <= bank_len_i[i*LW +: LW];
              r_addr[i] <= '0;
            end
            r_total <= w_len_sum;
            r_hv    <= '0;
            r_first <= 1'b1;
            if (w_len_sum == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= S_PRIME;
            end
          end
        end
        S_PRIME: begin
          for (int i = 0; i < RAM_N; i++) begin
            r_addr[i] <= AWIDTH'(1);
          end
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          for (int i = 0; i < RAM_N; i++) begin
            if (r_pend[i]) begin
              r_head[i] <= rd_data_i[i*DWIDTH +: DWIDTH];
              r_hv[i]   <= 1'b1;
            end
          end
          r_state <= S_OUTPUT;
        end
        S_OUTPUT: begin
          if (w_hs) begin
            r_rem[w_sel]  <= w_sel_rem - LW'(1);
            r_addr[w_sel] <= r_addr[w_sel] + AWIDTH'(1);
            r_hv[w_sel]   <= 1'b0;
            r_total       <= r_total - TW'(1);
            r_first       <= 1'b0;
            if (r_total == TW'(1)) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else if (w_refill) begin
              r_state <= S_WAIT;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o              = (r_state != S_IDLE);
  assign done_o              = r_done;
  assign src_valid_o         = (r_state == S_OUTPUT);
  assign src_data_o          = src_valid_o ? w_best : '0;
  assign src_startofpacket_o = src_valid_o && r_first;
  assign src_endofpacket_o   = src_valid_o && (r_total == TW'(1));

endmodule
`default_nettype wire

// File: tb/tb_sort_merge_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_sort_merge_scheduler
// Description : Scoreboard bench for sort_merge_scheduler with a bank RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sort_merge_scheduler;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int RN = 4;
  localparam int LW = AW + 1;

  logic              clk = 1'b0;
  logic              srst;
  logic              start;
  logic [RN*LW-1:0]  bank_len;
  logic              busy;
  logic              done;
  logic [RN-1:0]     rd_en;
  logic [RN*AW-1:0]  rd_addr;
  logic [RN*DW-1:0]  rd_data = '0;
  logic [DW-1:0]     src_data;
  logic              src_valid;
  logic              src_sop;
  logic              src_eop;
  logic              src_ready;

  always #5 clk = ~clk;

  sort_merge_scheduler #(.DWIDTH(DW), .AWIDTH(AW), .RAM_N(RN)) dut (
    .clk_i               (clk),
    .srst_i              (srst),
    .start_i             (start),
    .bank_len_i          (bank_len),
    .busy_o              (busy),
    .done_o              (done),
    .rd_en_o             (rd_en),
    .rd_addr_o           (rd_addr),
    .rd_data_i           (rd_data),
    .src_data_o          (src_data),
    .src_valid_o         (src_valid),
    .src_startofpacket_o (src_sop),
    .src_endofpacket_o   (src_eop),
    .src_ready_i         (src_ready)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic          sop;
    logic          eop;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] mem [RN][256];
  int            cur_len [RN];
  int            rd_cnt [RN];
  int            hs_cnt   = 0;
  int            done_cnt = 0;
  int            n_checks = 0;
  int            n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Bank RAM: one-cycle read latency.
  always @(posedge clk) begin
    for (int i = 0; i < RN; i++) begin
      if (rd_en[i]) rd_data[i*DW +: DW] <= mem[i][rd_addr[i*AW +: AW]];
    end
  end

  // Monitor: pops the scoreboard on every handshake, checks stall stability.
  logic          stalled = 1'b0;
  logic [DW-1:0] held_d;
  logic          held_sop, held_eop;
  initial for (int i = 0; i < RN; i++) rd_cnt[i] = 0;

  always @(negedge clk) begin
    if (srst) begin
      stalled = 1'b0;
    end else begin
      for (int i = 0; i < RN; i++) begin
        if (rd_en[i]) begin
          rd_cnt[i]++;
          check("rd_addr_range", 32'(int'(rd_addr[i*AW +: AW]) < cur_len[i]), 32'd1);
        end
      end
      if (src_valid) begin
        if (stalled) begin
          check("stall_hold_data", 32'(src_data), 32'(held_d));
          check("stall_hold_sop",  32'(src_sop),  32'(held_sop));
          check("stall_hold_eop",  32'(src_eop),  32'(held_eop));
        end
        if (src_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("data", 32'(src_data), 32'(e.d));
            check("sop",  32'(src_sop),  32'(e.sop));
            check("eop",  32'(src_eop),  32'(e.eop));
          end
          hs_cnt++;
          stalled = 1'b0;
        end else begin
          stalled  = 1'b1;
          held_d   = src_data;
          held_sop = src_sop;
          held_eop = src_eop;
        end
      end else begin
        stalled = 1'b0;
      end
      if (done) begin
        done_cnt++;
        check("busy_low_at_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic expect_word(input logic [DW-1:0] d, input logic s, input logic e);
    exp_t x;
    x.d = d; x.sop = s; x.eop = e;
    exp_q.push_back(x);
  endtask

  task automatic set_len(input int l0, input int l1, input int l2, input int l3);
    bank_len = {LW'(l3), LW'(l2), LW'(l1), LW'(l0)};
    cur_len[0] = l0; cur_len[1] = l1; cur_len[2] = l2; cur_len[3] = l3;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int limit);
    int n = 0;
    while (done_cnt == base && n < limit) begin
      @(posedge clk);
      n++;
    end
    check("done_timeout", 32'(done_cnt != base), 32'd1);
  endtask

  task automatic load_a();
`ifdef SORT_MERGE_DESCENDING_EN
    mem[0][0] = 9; mem[0][1] = 5; mem[0][2] = 1;
    mem[1][0] = 3; mem[1][1] = 2;
`else
    mem[0][0] = 1; mem[0][1] = 5; mem[0][2] = 9;
    mem[1][0] = 2; mem[1][1] = 3;
`endif
    mem[3][0] = 4;
    set_len(3, 2, 0, 1);
  endtask

  task automatic expect_a();
`ifdef SORT_MERGE_DESCENDING_EN
    expect_word(9, 1, 0); expect_word(5, 0, 0); expect_word(4, 0, 0);
    expect_word(3, 0, 0); expect_word(2, 0, 0); expect_word(1, 0, 1);
`else
    expect_word(1, 1, 0); expect_word(2, 0, 0); expect_word(3, 0, 0);
    expect_word(4, 0, 0); expect_word(5, 0, 0); expect_word(9, 0, 1);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, hs0, n;
    int snap [RN];
    logic [DW-1:0] vals[$];

    srst = 1'b1; start = 1'b0; src_ready = 1'b1;
    for (int i = 0; i < RN; i++) for (int j = 0; j < 256; j++) mem[i][j] = '0;
    set_len(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 srst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_busy",  32'(busy), 0);
    check("rst_done",  32'(done), 0);
    check("rst_rd_en", 32'(rd_en), 0);
    check("rst_addr",  32'(rd_addr), 0);
    check("rst_valid", 32'(src_valid), 0);
    check("rst_sop",   32'(src_sop), 0);
    check("rst_eop",   32'(src_eop), 0);
    check("rst_data",  32'(src_data), 0);

    // Scenario A: four banks, one empty
    load_a();
    expect_a();
    for (int i = 0; i < RN; i++) snap[i] = rd_cnt[i];
    base = done_cnt;
    pulse_start();
    @(negedge clk);
    check("prime_rd_en", 32'(rd_en), 32'b1011);
    check("prime_addr",  32'(rd_addr), 0);
    check("prime_busy",  32'(busy), 1);
    @(negedge clk);
    check("wait_valid",  32'(src_valid), 0);
    @(negedge clk);
    check("first_valid_latency", 32'(src_valid), 1);
    wait_done(base, 100);
    repeat (3) @(posedge clk);
    check("a_done_once",  32'(done_cnt - base), 1);
    check("a_queue_empty", 32'(exp_q.size()), 0);
    check("a_bank0_reads", 32'(rd_cnt[0] - snap[0]), 3);
    check("a_bank1_reads", 32'(rd_cnt[1] - snap[1]), 2);
    check("a_bank2_reads", 32'(rd_cnt[2] - snap[2]), 0);
    check("a_bank3_reads", 32'(rd_cnt[3] - snap[3]), 1);

    // Tie: bank 0 must win, so its refill comes first
`ifdef SORT_MERGE_DESCENDING_EN
    mem[0][0] = 7; mem[0][1] = 6; mem[1][0] = 7;
    expect_word(7, 1, 0); expect_word(7, 0, 0); expect_word(6, 0, 1);
`else
    mem[0][0] = 7; mem[0][1] = 8; mem[1][0] = 7;
    expect_word(7, 1, 0); expect_word(7, 0, 0); expect_word(8, 0, 1);
`endif
    set_len(2, 1, 0, 0);
    for (int i = 0; i < RN; i++) snap[i] = rd_cnt[i];
    base = done_cnt;
    pulse_start();
    repeat (3) @(negedge clk);
    check("tie_refill_bank0", 32'(rd_en), 32'b0001);
    @(negedge clk);
    check("tie_wait_after_bank0", 32'(src_valid), 0);
    wait_done(base, 100);
    repeat (2) @(posedge clk);
    check("tie_bank1_reads", 32'(rd_cnt[1] - snap[1]), 1);
    check("tie_queue_empty", 32'(exp_q.size()), 0);

    // All lengths zero
    set_len(0, 0, 0, 0);
    base = done_cnt;
    pulse_start();
    @(negedge clk);
    check("zero_done_pulse", 32'(done), 1);
    check("zero_busy", 32'(busy), 0);
    @(negedge clk);
    check("zero_done_single", 32'(done), 0);
    check("zero_valid", 32'(src_valid), 0);
    check("zero_busy2", 32'(busy), 0);

    // 32-word merge with random backpressure
    vals.delete();
    for (int i = 0; i < RN; i++) begin
      for (int j = 0; j < 8; j++) begin
`ifdef SORT_MERGE_DESCENDING_EN
        mem[i][j] = DW'(100 - (j * 3 + i));
`else
        mem[i][j] = DW'(j * 3 + i);
`endif
        vals.push_back(mem[i][j]);
      end
    end
`ifdef SORT_MERGE_DESCENDING_EN
    vals.rsort();
`else
    vals.sort();
`endif
    for (int k = 0; k < 32; k++) expect_word(vals[k], k == 0, k == 31);
    set_len(8, 8, 8, 8);
    base = done_cnt;
    hs0  = hs_cnt;
    pulse_start();
    n = 0;
    while (done_cnt == base && n < 2000) begin
      @(posedge clk);
      #1 src_ready = 1'($urandom_range(0, 1));
      n++;
    end
    src_ready = 1'b1;
    check("rand_done_timeout", 32'(done_cnt != base), 1);
    check("rand_handshakes", 32'(hs_cnt - hs0), 32);
    check("rand_queue_empty", 32'(exp_q.size()), 0);

    // Reset after the third handshake
    load_a();
    expect_a();
    base = done_cnt;
    hs0  = hs_cnt;
    pulse_start();
    n = 0;
    while (hs_cnt < hs0 + 3 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("mid_rst_reach3", 32'(hs_cnt - hs0), 3);
    #1 srst = 1'b1; src_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_valid", 32'(src_valid), 0);
    check("mid_rst_rd_en", 32'(rd_en), 0);
    check("mid_rst_busy",  32'(busy), 0);
    check("mid_rst_done",  32'(done), 0);
    check("mid_rst_eop",   32'(src_eop), 0);
    check("mid_rst_addr",  32'(rd_addr), 0);
    exp_q.delete();
    @(posedge clk);
    #1 srst = 1'b0; src_ready = 1'b1;
    repeat (4) @(posedge clk);
    check("mid_rst_no_done", 32'(done_cnt - base), 0);

    expect_a();
    base = done_cnt;
    pulse_start();
    wait_done(base, 100);
    repeat (2) @(posedge clk);
    check("post_rst_queue_empty", 32'(exp_q.size()), 0);
    check("post_rst_done_once", 32'(done_cnt - base), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
